opb_simulink2opb_master: RTL and testbench
==========================================

Name: opb_simulink2opb_master

Overview:
- Single-outstanding OPB bus master. The user side issues one read or write command at a time; the block runs that command on OPB and returns exactly one response with a status code.
- It is the initiator-side counterpart to the ppc2simulink OPB slave registers. It drives the same OPB slave-facing bus, so user/Simulink logic can read and write any OPB slave, and benches can exercise slaves without a PowerPC.

Parameters:
- C_OPB_AWIDTH, 32, OPB address width; only 32 supported.
- C_OPB_DWIDTH, 32, OPB data width; only 32 supported.
- C_TIMEOUT, 16, number of unsuppressed select cycles with no acknowledge before the block aborts with TIMEOUT; range 2..255.
- C_MAX_RETRY, 8, number of Sl_retry terminations accepted before the block aborts with RETRY_EXHAUSTED; range 1..255.

Ports:
- OPB_Clk  in  1  Sole clock.
- OPB_Rst  in  1  Asynchronous, active-low reset.
- cmd_valid  in  1  Command request.
- cmd_ready  out  1  High when the block can accept a command; high only in IDLE.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  [31:0]  Byte address.
- cmd_be  in  [3:0]  Byte enables.
- cmd_wdata  in  [31:0]  Write data.
- rsp_valid  out  1  One-cycle response strobe.
- rsp_status  out  [1:0]  00 OK, 01 TIMEOUT, 10 ERR, 11 RETRY_EXHAUSTED.
- rsp_rdata  out  [31:0]  Read data.
- M_select  out  1  OPB select.
- M_RNW  out  1  OPB read/not-write.
- M_ABus  out  [0:31]  OPB address bus.
- M_BE  out  [0:3]  OPB byte enables.
- M_DBus  out  [0:31]  OPB write data bus.
- M_seqAddr  out  1  Sequential-address indicator; tied 0.
- Sl_DBus  in  [0:31]  Slave read data.
- Sl_xferAck  in  1  Slave transfer acknowledge.
- Sl_errAck  in  1  Slave error acknowledge.
- Sl_retry  in  1  Slave retry request.
- Sl_toutSup  in  1  Slave timeout suppress.

Behaviour:
- Bit mapping: user bit n maps to OPB bit (width-1-n). Example: M_ABus[0] = cmd_addr[31], M_BE[0] = cmd_be[3].
- Reset:
  - State goes to IDLE; all counters clear.
  - All M_* outputs, rsp_valid, rsp_status and rsp_rdata are 0; cmd_ready is 1.
  - Reset asserted mid-transfer drops M_select immediately (asynchronously) and no response is issued.
- OPB bus outputs are OR-combined, so M_ABus, M_BE, M_DBus and M_RNW must be all-zero whenever M_select is 0. M_DBus is also 0 during reads.
- FSM states: IDLE, BUS, GAP, RESP.
  - IDLE: on cmd_valid && cmd_ready, capture the command, clear both counters, go to BUS.
  - BUS: M_select is 1 and the captured command is driven (registered outputs). Responses are evaluated every cycle with priority errAck > xferAck > retry > timeout:
    - Sl_errAck: status ERR, go to RESP.
    - Sl_xferAck: status OK; on a read, capture Sl_DBus into rsp_rdata; go to RESP.
    - Sl_retry: increment retry_cnt. If retry_cnt reaches C_MAX_RETRY, status RETRY_EXHAUSTED and go to RESP; otherwise go to GAP.
    - Otherwise, if Sl_toutSup is 0, increment tout_cnt. When tout_cnt reaches C_TIMEOUT, status TIMEOUT and go to RESP. If Sl_toutSup is 1, tout_cnt holds (it is not cleared).
  - GAP: M_select is 0 for exactly one cycle; clear tout_cnt; return to BUS. retry_cnt is not cleared.
  - RESP: M_select is 0; rsp_valid is 1 for exactly one cycle; go to IDLE.
- rsp_rdata is 0 for writes and for any non-OK status. rsp_status and rsp_rdata hold their values until the next RESP.
- Latency: command accepted at edge 0; M_select high in cycle 1; a slave ack in cycle 1 gives rsp_valid in cycle 2. Minimum issue rate is one command every 3 cycles.
- Inputs are ignored outside BUS; a stray xferAck in IDLE, GAP or RESP has no effect.
- cmd_* inputs are sampled only on acceptance; later changes do not affect the transfer in progress.

Test Plan:
- Write 0xDEADBEEF, be=0xF, addr 0x01000000; slave xferAck in the first select cycle -> M_select high exactly 1 cycle, M_ABus=0x01000000, M_DBus=0xDEADBEEF; rsp_valid at cycle 2 with status 00, rdata 0.
- Read, addr 0x01000004; slave acks after 3 wait cycles with Sl_DBus=0x12345678 -> select high 4 cycles, M_DBus=0 throughout; rsp status 00, rdata 0x12345678.
- No slave response, C_TIMEOUT=16 -> select high 16 cycles, then rsp status 01; then hold toutSup=1 for 40 cycles followed by xferAck -> status 00 with no timeout.
- Slave asserts retry 7 times then xferAck (C_MAX_RETRY=8) -> 7 one-cycle select gaps, final status 00. Retry on all 8 attempts -> status 11 and no further select.
- errAck and xferAck asserted in the same cycle -> status 10, rdata 0. Reset asserted in the 2nd BUS cycle -> select low immediately, no rsp_valid, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/opb_simulink2opb_master_if.sv
// User command/response handshake plus OPB master/slave bus signals.
// OPB vectors keep the big-endian [0:n] numbering of the bus.
interface opb_simulink2opb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rnw;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        M_select;
    logic        M_RNW;
    logic [0:31] M_ABus;
    logic [0:3]  M_BE;
    logic [0:31] M_DBus;
    logic        M_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
        output cmd_ready, rsp_valid, rsp_status, rsp_rdata,
        output M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr
    );

    modport slave (
        output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
        input  cmd_ready, rsp_valid, rsp_status, rsp_rdata,
        input  M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr
    );
endinterface

// File: rtl/opb_simulink2opb_master.sv
// Single-outstanding OPB master: one user command in, one OPB transfer
// (with retry/timeout handling), one status response out.
module opb_simulink2opb_master #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32,
    parameter int C_TIMEOUT    = 16,
    parameter int C_MAX_RETRY  = 8
) (
    input logic                         OPB_Clk,
    input logic                         OPB_Rst,
    opb_simulink2opb_master_if.master   bus
);

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;
    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_TIMEOUT  = 2'b01,
        ST_ERR      = 2'b10,
        ST_RETRY_EX = 2'b11
    } status_t;

    localparam logic [7:0] TOUT_LIM  = 8'(C_TIMEOUT);
    localparam logic [7:0] RETRY_LIM = 8'(C_MAX_RETRY);

    state_t                    state, state_d;
    status_t                   status_q, status_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [7:0]                retry_cnt, retry_d;
    logic [7:0]                tout_cnt, tout_d;
    logic                      capture;
    logic                      rnw_q;
    logic [C_OPB_AWIDTH-1:0]   addr_q;
    logic [3:0]                be_q;
    logic [C_OPB_DWIDTH-1:0]   wdata_q;
    logic                      sel;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state     <= IDLE;
            status_q  <= ST_OK;
            rdata_q   <= '0;
            retry_cnt <= '0;
            tout_cnt  <= '0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            retry_cnt <= retry_d;
            tout_cnt  <= tout_d;
            if (capture) begin
                rnw_q   <= bus.cmd_rnw;
                addr_q  <= bus.cmd_addr;
                be_q    <= bus.cmd_be;
                wdata_q <= bus.cmd_wdata;
            end
        end
    end

    always_comb begin
        state_d  = state;
        status_d = status_q;
        rdata_d  = rdata_q;
        retry_d  = retry_cnt;
        tout_d   = tout_cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    capture = 1'b1;
                    retry_d = '0;
                    tout_d  = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Priority: errAck > xferAck > retry > timeout.
                if (bus.Sl_errAck) begin
                    status_d = ST_ERR;
                    rdata_d  = '0;
                    state_d  = RESP;
                end else if (bus.Sl_xferAck) begin
                    status_d = ST_OK;
                    rdata_d  = rnw_q ? bus.Sl_DBus : '0;
                    state_d  = RESP;
                end else if (bus.Sl_retry) begin
                    retry_d = retry_cnt + 8'd1;
                    if (retry_d == RETRY_LIM) begin
                        status_d = ST_RETRY_EX;
                        rdata_d  = '0;
                        state_d  = RESP;
                    end else begin
                        state_d = GAP;
                    end
                end else if (!bus.Sl_toutSup) begin
                    tout_d = tout_cnt + 8'd1;
                    if (tout_d == TOUT_LIM) begin
                        status_d = ST_TIMEOUT;
                        rdata_d  = '0;
                        state_d  = RESP;
                    end
                end
            end
            GAP: begin
                tout_d  = '0;
                state_d = BUS;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select comes straight from the state register so reset drops it at once;
    // the other bus outputs are gated to zero for the OR-combined OPB.
    assign sel            = (state == BUS);
    assign bus.M_select   = sel;
    assign bus.M_RNW      = sel & rnw_q;
    assign bus.M_ABus     = sel ? addr_q : '0;
    assign bus.M_BE       = sel ? be_q : '0;
    assign bus.M_DBus     = (sel && !rnw_q) ? wdata_q : '0;
    assign bus.M_seqAddr  = 1'b0;
    assign bus.cmd_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_status = status_q;
    assign bus.rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_opb_simulink2opb_master.sv
// Directed bench for opb_simulink2opb_master with a scripted OPB slave.
module tb_opb_simulink2opb_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic        exp_rnw;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    int          sel_cnt, gaps, rsp_cyc;
    logic        bus_ok, idle_ok;
    logic [1:0]  rsp_st;
    logic [31:0] rsp_rd;

    always #5 clk = ~clk;

    opb_simulink2opb_master_if bus ();

    opb_simulink2opb_master #(
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_TIMEOUT    (16),
        .C_MAX_RETRY  (8)
    ) dut (
        .OPB_Clk (clk),
        .OPB_Rst (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        bus.Sl_xferAck = 1'b0;
        bus.Sl_errAck  = 1'b0;
        bus.Sl_retry   = 1'b0;
        bus.Sl_toutSup = 1'b0;
        bus.Sl_DBus    = '0;
    endtask

    task automatic issue(input logic rnw, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        exp_rnw = rnw; exp_addr = addr; exp_be = be; exp_wdata = wd;
        @(negedge clk);
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        if (!bus.cmd_ready) check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = rnw;
        bus.cmd_addr  = addr;
        bus.cmd_be    = be;
        bus.cmd_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the command to show it is only sampled on acceptance.
        bus.cmd_valid = 1'b0;
        bus.cmd_rnw   = ~rnw;
        bus.cmd_addr  = ~addr;
        bus.cmd_be    = ~be;
        bus.cmd_wdata = ~wd;
    endtask

    // Scripted slave: the first n_retry select bursts get a retry on their first
    // cycle; the final burst waits n_wait cycles (toutSup = sup) then acks/errs.
    task automatic serve(input int n_wait, input int n_retry, input logic sup,
                         input logic ack, input logic err, input logic [31:0] word);
        int   a = 0;
        int   c = 0;
        logic prev_sel = 1'b0;
        logic seen = 1'b0;
        sel_cnt = 0; gaps = 0; rsp_cyc = 0; bus_ok = 1'b1; idle_ok = 1'b1;
        rsp_st = '0; rsp_rd = '0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                rsp_st  = bus.rsp_status;
                rsp_rd  = bus.rsp_rdata;
                slave_idle();
                break;
            end
            if (bus.M_select) begin
                sel_cnt++;
                seen = 1'b1;
                if (bus.M_ABus !== exp_addr || bus.M_BE !== exp_be ||
                    bus.M_RNW !== exp_rnw ||
                    bus.M_DBus !== (exp_rnw ? 32'h0 : exp_wdata) ||
                    bus.M_seqAddr !== 1'b0)
                    bus_ok = 1'b0;
                slave_idle();
                if (a < n_retry) begin
                    if (c == 0) bus.Sl_retry = 1'b1;
                end else if (c < n_wait) begin
                    bus.Sl_toutSup = sup;
                end else if (c == n_wait) begin
                    bus.Sl_xferAck = ack;
                    bus.Sl_errAck  = err;
                    bus.Sl_DBus    = word;
                end
                c++;
            end else begin
                if (prev_sel) begin
                    a++;
                    c = 0;
                end
                if (seen) gaps++;
                if (bus.M_ABus !== '0 || bus.M_BE !== '0 || bus.M_DBus !== '0 ||
                    bus.M_RNW !== 1'b0)
                    idle_ok = 1'b0;
                slave_idle();
            end
            prev_sel = bus.M_select;
        end
        if (rsp_cyc == 0) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic flag;
        bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = '0;
        bus.cmd_be = '0; bus.cmd_wdata = '0;
        slave_idle();

        repeat (2) @(negedge clk);
        check("rst_select", 32'(bus.M_select), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_status", 32'(bus.rsp_status), 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_abus", bus.M_ABus | bus.M_DBus | 32'(bus.M_BE) | 32'(bus.M_RNW), 32'd0);
        rst_n = 1'b1;

        // Stray acknowledge while idle must be ignored.
        flag = 1'b0;
        bus.Sl_xferAck = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.M_select) flag = 1'b1;
        end
        bus.Sl_xferAck = 1'b0;
        check("stray_ack", 32'(flag), 32'd0);

        // Write, immediate ack.
        issue(1'b0, 32'h0100_0000, 4'hF, 32'hDEAD_BEEF);
        serve(0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        check("wr_sel_cycles", 32'(sel_cnt), 32'd1);
        check("wr_rsp_cycle", 32'(rsp_cyc), 32'd2);
        check("wr_status", 32'(rsp_st), 32'd0);
        check("wr_rdata", rsp_rd, 32'd0);
        check("wr_bus", 32'(bus_ok), 32'd1);
        @(negedge clk);
        check("wr_ready_after", 32'(bus.cmd_ready), 32'd1);

        // Read, 3 wait cycles, partial byte enables.
        issue(1'b1, 32'h0100_0004, 4'h6, 32'h0);
        serve(3, 0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        check("rd_sel_cycles", 32'(sel_cnt), 32'd4);
        check("rd_status", 32'(rsp_st), 32'd0);
        check("rd_rdata", rsp_rd, 32'h1234_5678);
        check("rd_bus", 32'(bus_ok), 32'd1);
        repeat (3) @(negedge clk);
        check("rd_hold_status", 32'(bus.rsp_status), 32'd0);
        check("rd_hold_rdata", bus.rsp_rdata, 32'h1234_5678);

        // No slave response: timeout after 16 select cycles.
        issue(1'b1, 32'h0200_0000, 4'hF, 32'h0);
        serve(1000, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("to_sel_cycles", 32'(sel_cnt), 32'd16);
        check("to_status", 32'(rsp_st), 32'd1);
        check("to_rdata", rsp_rd, 32'd0);

        // Timeout suppressed for 40 cycles, then ack.
        issue(1'b0, 32'h0200_0004, 4'h3, 32'h0BAD_F00D);
        serve(40, 0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("sup_sel_cycles", 32'(sel_cnt), 32'd41);
        check("sup_status", 32'(rsp_st), 32'd0);
        check("sup_bus", 32'(bus_ok), 32'd1);

        // Seven retries then ack.
        issue(1'b1, 32'h0100_0010, 4'hF, 32'h0);
        serve(0, 7, 1'b0, 1'b1, 1'b0, 32'hA5A5_5A5A);
        check("rty7_sel_cycles", 32'(sel_cnt), 32'd8);
        check("rty7_gaps", 32'(gaps), 32'd7);
        check("rty7_status", 32'(rsp_st), 32'd0);
        check("rty7_rdata", rsp_rd, 32'hA5A5_5A5A);
        check("rty7_idle_zero", 32'(idle_ok), 32'd1);

        // Retry on every attempt: exhausted after 8.
        issue(1'b0, 32'h0100_0014, 4'h8, 32'h1111_2222);
        serve(0, 8, 1'b0, 1'b1, 1'b0, 32'h0);
        check("rty8_sel_cycles", 32'(sel_cnt), 32'd8);
        check("rty8_gaps", 32'(gaps), 32'd7);
        check("rty8_status", 32'(rsp_st), 32'd3);
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.M_select) flag = 1'b1;
        end
        check("rty8_no_select", 32'(flag), 32'd0);

        // errAck wins over xferAck.
        issue(1'b1, 32'h0300_0000, 4'hF, 32'h0);
        serve(0, 0, 1'b0, 1'b1, 1'b1, 32'hCAFE_BABE);
        check("err_sel_cycles", 32'(sel_cnt), 32'd1);
        check("err_status", 32'(rsp_st), 32'd2);
        check("err_rdata", rsp_rd, 32'd0);

        // Reset in the second BUS cycle.
        issue(1'b1, 32'h0100_0008, 4'hF, 32'h0);
        @(negedge clk);
        check("rstm_sel_c1", 32'(bus.M_select), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_sel_drop", 32'(bus.M_select), 32'd0);
        check("rstm_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.M_select) flag = 1'b1;
        end
        check("rstm_no_rsp", 32'(flag), 32'd0);
        check("rstm_ready", 32'(bus.cmd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
